axil_reg_arbiter: RTL

Two-requester AXI4-Lite master front end that shares the single register port of the constant peripheral (four 32-bit registers at offsets 0x0–0xC) between two internal clients: the MicroBlaze-side command bridge and the pitch-detection update path. It accepts simple register-access requests, grants them round-robin, and runs exactly one AXI4-Lite transaction at a time. It returns a one-cycle response pulse with read data and an error flag to the granted requester.

---
 rtl/axil_arb_pkg.sv | 24 ++
 rtl/axil_reg_arbiter_if.sv | 57 +++++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/axil_reg_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package axil_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  // Either of the two AXI error responses reports as a requester error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the register peripheral (slave).
interface axil_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester that was not granted most recently. Requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester that wins the next tie.
  logic prio_reg;

  // Combinational one-hot grant from the current requests and tie priority.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Hand tie priority to the other requester only when a grant is actually taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prio_reg <= 1'b0;
    end else if (advance) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/axil_reg_arbiter.sv
// Shares one AXI4-Lite register port between two internal requesters. One
// transaction is in flight at a time; each ends with a single-cycle response
// pulse to the requester that issued it.
module axil_reg_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            rq_valid,
  output logic [NUM_REQ-1:0]            rq_ready,
  input  logic [NUM_REQ-1:0]            rq_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  axil_reg_arbiter_if.master            m_axi
);

  state_t                  state_reg;
  logic                    owner_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic [NUM_REQ-1:0]      rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic                    rsp_err_reg;

  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      accept;
  logic                    acc_idx;
  logic                    acc_misaligned;
  logic [NUM_REQ-1:0]      owner_mask;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  // Unpack the flat request buses and gate grants to the IDLE state.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]  = rq_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = rq_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign rq_ready[gi]  = (state_reg == IDLE) && grant[gi];
  end

  assign accept         = rq_valid & rq_ready;
  assign acc_idx        = accept[1];
  assign acc_misaligned = (addr_arr[acc_idx][1:0] != 2'b00);
  assign owner_mask     = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_reg;

  // A write channel is finished once its valid has been taken, or is taken now.
  assign aw_done = !awvalid_reg || m_axi.awready;
  assign w_done  = !wvalid_reg  || m_axi.wready;

  rr_arbiter2 u_arb (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .req     (rq_valid),
    .advance (|accept),
    .grant   (grant)
  );

  // Transaction FSM; all AXI drivers and response outputs are registered here.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|accept) begin
            owner_reg <= acc_idx;
            addr_reg  <= addr_arr[acc_idx];
            wdata_reg <= wdata_arr[acc_idx];
            if (acc_misaligned) begin
              // Never reaches the bus; answer straight away with an error.
              state_reg     <= RESP;
              rsp_valid_reg <= accept;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else if (rq_write[acc_idx]) begin
              state_reg   <= WR;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= RD_ADDR;
              arvalid_reg <= 1'b1;
            end
          end
        end
        WR: begin
          if (awvalid_reg && m_axi.awready) awvalid_reg <= 1'b0;
          if (wvalid_reg && m_axi.wready) wvalid_reg <= 1'b0;
          if (aw_done && w_done) begin
            state_reg  <= WR_RESP;
            bready_reg <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_reg    <= 1'b0;
            rsp_valid_reg <= owner_mask;
            rsp_err_reg   <= resp_is_err(m_axi.bresp);
            rsp_rdata_reg <= '0;
            state_reg     <= RESP;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_reg    <= 1'b0;
            rsp_valid_reg <= owner_mask;
            rsp_err_reg   <= resp_is_err(m_axi.rresp);
            rsp_rdata_reg <= resp_is_err(m_axi.rresp) ? '0 : m_axi.rdata;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_reg <= '0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_reg;
  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

endmodule
